wb_cdb_arbiter: RTL and testbench

Downstream consumer of the functional-unit writeback interfaces: ALU, branch, LSU and MUL/DIV.
Arbitrates up to N_SRC valid/ready writeback sources onto one registered common data bus (CDB). The CDB drives ROB completion, PRF write and RS wakeup.
Filters wrong-path results by epoch and drops them without broadcasting.
Round-robin fairness prevents any FU output buffer from starving.

---
 rtl/wb_cdb_arbiter_pkg.sv | 33 +++
 rtl/wb_cdb_arbiter_rr.sv | 44 ++++
 rtl/wb_cdb_arbiter.sv | 127 ++++++++++++
 tb/tb_wb_cdb_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_cdb_arbiter_pkg
// Description : Shared widths, CDB packet type and helpers for the writeback
//               CDB arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_cdb_arbiter_pkg;

    localparam int ROB_W   = 6;
    localparam int PHYS_W  = 7;
    localparam int EPOCH_W = 3;

    typedef struct packed {
        logic [31:0]        pc;
        logic               uses_rd;
        logic [ROB_W-1:0]   rob_idx;
        logic [PHYS_W-1:0]  prd_new;
        logic [EPOCH_W-1:0] epoch;
        logic [31:0]        data;
    } cdb_pkt_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_cdb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : wb_cdb_arbiter_rr
// Description : Combinational round-robin arbiter; scans from ptr upward with
//               wrap and returns a one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_cdb_arbiter_rr #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // ptr < N and k < N, so one conditional subtract is a full modulo
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!any_grant && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
                any_grant    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_cdb_arbiter
// Description : Arbitrates FU writeback sources onto one registered CDB,
//               dropping wrong-epoch results and counting the drops.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_cdb_arbiter
    import wb_cdb_arbiter_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int SRC_IDX_W  = $clog2(N_SRC),
    parameter int DROP_CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_SRC-1:0]                src_valid,
    output logic [N_SRC-1:0]                src_ready,
    input  logic [N_SRC-1:0][31:0]          src_pc,
    input  logic [N_SRC-1:0]                src_uses_rd,
    input  logic [N_SRC-1:0][ROB_W-1:0]     src_rob_idx,
    input  logic [N_SRC-1:0][PHYS_W-1:0]    src_prd_new,
    input  logic [N_SRC-1:0][EPOCH_W-1:0]   src_epoch,
    input  logic [N_SRC-1:0][31:0]          src_data,
    input  logic                            flush_valid,
    input  logic [EPOCH_W-1:0]              flush_epoch,
    output logic                            cdb_valid,
    output logic [31:0]                     cdb_pc,
    output logic                            cdb_uses_rd,
    output logic [ROB_W-1:0]                cdb_rob_idx,
    output logic [PHYS_W-1:0]               cdb_prd_new,
    output logic [EPOCH_W-1:0]              cdb_epoch,
    output logic [31:0]                     cdb_data,
    output logic [SRC_IDX_W-1:0]            cdb_src_idx,
    output logic [DROP_CNT_W-1:0]           drop_cnt
);

    cdb_pkt_t                w_pkt [N_SRC];
    logic [N_SRC-1:0]        w_stale;
    logic [N_SRC-1:0]        w_live;
    logic [N_SRC-1:0]        w_grant;
    logic [SRC_IDX_W-1:0]    w_grant_idx;
    logic                    w_any_grant;
    logic [N_SRC-1:0]        w_ready;
    logic [7:0]              w_drop8;
    logic [3:0]              w_drop_pop;
    logic [DROP_CNT_W:0]     w_drop_sum;
    logic [SRC_IDX_W-1:0]    w_ptr_next;

    logic [EPOCH_W-1:0]      r_cur_epoch;
    logic [SRC_IDX_W-1:0]    r_rr_ptr;
    logic                    r_cdb_valid;
    cdb_pkt_t                r_cdb_pkt;
    logic [SRC_IDX_W-1:0]    r_cdb_src_idx;
    logic [DROP_CNT_W-1:0]   r_drop_cnt;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pack
            assign w_pkt[gi] = '{pc:      src_pc[gi],
                                 uses_rd: src_uses_rd[gi],
                                 rob_idx: src_rob_idx[gi],
                                 prd_new: src_prd_new[gi],
                                 epoch:   src_epoch[gi],
                                 data:    src_data[gi]};
            assign w_stale[gi] = src_valid[gi] && (src_epoch[gi] != r_cur_epoch);
            assign w_live[gi]  = src_valid[gi] && !w_stale[gi];
        end
    endgenerate

    wb_cdb_arbiter_rr #(
        .N     (N_SRC),
        .IDX_W (SRC_IDX_W)
    ) u_rr (
        .req       (w_live),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_grant (w_any_grant)
    );

    // Ready depends only on inputs, epoch and pointer, never on CDB state
    assign w_ready   = (rst || flush_valid) ? '0 : (w_stale | w_grant);
    assign src_ready = w_ready;

    always_comb begin
        w_drop8              = '0;
        w_drop8[N_SRC-1:0]   = w_stale & w_ready;
    end

    assign w_drop_pop = popcount8(w_drop8);
    assign w_drop_sum = {1'b0, r_drop_cnt} + {{(DROP_CNT_W-3){1'b0}}, w_drop_pop};
    assign w_ptr_next = (w_grant_idx == SRC_IDX_W'(N_SRC-1)) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_epoch   <= '0;
            r_rr_ptr      <= '0;
            r_cdb_valid   <= 1'b0;
            r_cdb_pkt     <= '0;
            r_cdb_src_idx <= '0;
            r_drop_cnt    <= '0;
        end else if (flush_valid) begin
            r_cur_epoch <= flush_epoch;
            r_cdb_valid <= 1'b0;
        end else begin
            r_cdb_valid <= w_any_grant;
            if (w_any_grant) begin
                r_cdb_pkt     <= w_pkt[w_grant_idx];
                r_cdb_src_idx <= w_grant_idx;
                r_rr_ptr      <= w_ptr_next;
            end
            r_drop_cnt <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_pc      = r_cdb_pkt.pc;
    assign cdb_uses_rd = r_cdb_pkt.uses_rd;
    assign cdb_rob_idx = r_cdb_pkt.rob_idx;
    assign cdb_prd_new = r_cdb_pkt.prd_new;
    assign cdb_epoch   = r_cdb_pkt.epoch;
    assign cdb_data    = r_cdb_pkt.data;
    assign cdb_src_idx = r_cdb_src_idx;
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_cdb_arbiter
// Description : Randomized bench for wb_cdb_arbiter against a queue-free
//               behavioural model of epoch filtering and round-robin grants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_cdb_arbiter;
    import wb_cdb_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int IW   = 2;
    localparam int DW   = 4;
    localparam int DMAX = (1 << DW) - 1;

    logic                        clk;
    logic                        rst;
    logic [N-1:0]                src_valid;
    logic [N-1:0]                src_ready;
    logic [N-1:0][31:0]          src_pc;
    logic [N-1:0]                src_uses_rd;
    logic [N-1:0][ROB_W-1:0]     src_rob_idx;
    logic [N-1:0][PHYS_W-1:0]    src_prd_new;
    logic [N-1:0][EPOCH_W-1:0]   src_epoch;
    logic [N-1:0][31:0]          src_data;
    logic                        flush_valid;
    logic [EPOCH_W-1:0]          flush_epoch;
    logic                        cdb_valid;
    logic [31:0]                 cdb_pc;
    logic                        cdb_uses_rd;
    logic [ROB_W-1:0]            cdb_rob_idx;
    logic [PHYS_W-1:0]           cdb_prd_new;
    logic [EPOCH_W-1:0]          cdb_epoch;
    logic [31:0]                 cdb_data;
    logic [IW-1:0]               cdb_src_idx;
    logic [DW-1:0]               drop_cnt;

    wb_cdb_arbiter #(.N_SRC(N), .SRC_IDX_W(IW), .DROP_CNT_W(DW)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_pc(src_pc), .src_uses_rd(src_uses_rd), .src_rob_idx(src_rob_idx),
        .src_prd_new(src_prd_new), .src_epoch(src_epoch), .src_data(src_data),
        .flush_valid(flush_valid), .flush_epoch(flush_epoch),
        .cdb_valid(cdb_valid), .cdb_pc(cdb_pc), .cdb_uses_rd(cdb_uses_rd),
        .cdb_rob_idx(cdb_rob_idx), .cdb_prd_new(cdb_prd_new), .cdb_epoch(cdb_epoch),
        .cdb_data(cdb_data), .cdb_src_idx(cdb_src_idx), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int       m_epoch, m_ptr, m_drop, m_win;
    bit       m_cv;
    cdb_pkt_t m_pkt;
    int       m_idx;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_epoch = 0; m_ptr = 0; m_drop = 0; m_cv = 0;
    endtask

    task automatic new_src(input int i, input bit stale_ok);
        src_valid[i]   = 1'b1;
        src_pc[i]      = $urandom;
        src_uses_rd[i] = 1'($urandom);
        src_rob_idx[i] = ROB_W'($urandom);
        src_prd_new[i] = PHYS_W'($urandom);
        src_data[i]    = $urandom;
        src_epoch[i]   = (stale_ok && ($urandom_range(0, 3) == 0)) ?
                         EPOCH_W'($urandom) : EPOCH_W'(m_epoch);
    endtask

    // Called just after a negedge with inputs already set; ends at next negedge
    task automatic step();
        logic [N-1:0] exp_rdy;
        int           n_stale;
        exp_rdy = '0;
        n_stale = 0;
        m_win   = -1;
        #1;
        if (!flush_valid) begin
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && (int'(src_epoch[i]) != m_epoch)) begin
                    exp_rdy[i] = 1'b1;
                    n_stale++;
                end
            end
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (m_win < 0 && src_valid[j] && (int'(src_epoch[j]) == m_epoch)) m_win = j;
            end
            if (m_win >= 0) exp_rdy[m_win] = 1'b1;
        end
        check_eq("src_ready", 64'(src_ready), 64'(exp_rdy));
        if (flush_valid) begin
            m_epoch = int'(flush_epoch);
            m_cv    = 0;
        end else begin
            m_drop = (m_drop + n_stale > DMAX) ? DMAX : m_drop + n_stale;
            m_cv   = (m_win >= 0);
            if (m_win >= 0) begin
                m_pkt = '{pc: src_pc[m_win], uses_rd: src_uses_rd[m_win],
                          rob_idx: src_rob_idx[m_win], prd_new: src_prd_new[m_win],
                          epoch: src_epoch[m_win], data: src_data[m_win]};
                m_idx = m_win;
                m_ptr = (m_win + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (exp_rdy[i]) src_valid[i] = 1'b0;
        check_eq("cdb_valid", 64'(cdb_valid), 64'(m_cv));
        check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (m_cv) begin
            check_eq("cdb_pc",      64'(cdb_pc),      64'(m_pkt.pc));
            check_eq("cdb_uses_rd", 64'(cdb_uses_rd), 64'(m_pkt.uses_rd));
            check_eq("cdb_rob_idx", 64'(cdb_rob_idx), 64'(m_pkt.rob_idx));
            check_eq("cdb_prd_new", 64'(cdb_prd_new), 64'(m_pkt.prd_new));
            check_eq("cdb_epoch",   64'(cdb_epoch),   64'(m_pkt.epoch));
            check_eq("cdb_data",    64'(cdb_data),    64'(m_pkt.data));
            check_eq("cdb_src_idx", 64'(cdb_src_idx), 64'(m_idx));
        end
        @(negedge clk);
        flush_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_ready", 64'(src_ready), 64'(0));
        check_eq("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check_eq("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        check_eq("rst_src_idx", 64'(cdb_src_idx), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int vprob;
        rst = 1'b1;
        src_valid = '0; src_pc = '0; src_uses_rd = '0; src_rob_idx = '0;
        src_prd_new = '0; src_epoch = '0; src_data = '0;
        flush_valid = 1'b0; flush_epoch = '0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // single ALU result, then an idle cycle
        src_valid[0] = 1'b1; src_pc[0] = 32'h100; src_uses_rd[0] = 1'b1;
        src_rob_idx[0] = 6'd5; src_prd_new[0] = 7'd9; src_epoch[0] = '0;
        src_data[0] = 32'h1234;
        step();
        step();

        // all sources live continuously: 1,2,3,0,... one per cycle
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) if (!src_valid[i]) new_src(i, 1'b0);
            step();
        end

        // flush while a now-stale entry waits, then it gets dropped
        for (int i = 0; i < N; i++) src_valid[i] = 1'b0;
        new_src(0, 1'b0);
        flush_valid = 1'b1; flush_epoch = 3'd2;
        step();
        step();

        vprob = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) vprob = $urandom_range(20, 100);
            for (int i = 0; i < N; i++)
                if (!src_valid[i] && ($urandom_range(1, 100) <= vprob)) new_src(i, 1'b1);
            if ($urandom_range(0, 15) == 0) begin
                flush_valid = 1'b1;
                flush_epoch = ($urandom_range(0, 1) == 0) ? EPOCH_W'(m_epoch) : EPOCH_W'($urandom);
            end
            if ((c % 400 == 399) && cdb_valid) begin
                flush_valid = 1'b0;
                do_reset();
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
